// File: rtl/csa_pipe_adder.sv
// rtl/csa_pipe_adder.sv - pipelined carry-select adder/subtractor, one BLOCK-bit block resolved per stage
// Define CSA_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module csa_pipe_adder #(
  parameter int N     = 16,
  parameter int BLOCK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         co
`ifdef CSA_PIPE_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int STAGES = N / BLOCK;

  logic [N-1:0] a_q [STAGES];
  logic [N-1:0] b_q [STAGES];
  logic [N-1:0] s_q [STAGES];
  logic         c_q [STAGES];
  logic         v_q [STAGES];

  logic [N-1:0] a_n [STAGES];
  logic [N-1:0] b_n [STAGES];
  logic [N-1:0] s_n [STAGES];
  logic         c_n [STAGES];
  logic         v_n [STAGES];

  logic stall;

  assign stall    = v_q[STAGES-1] & ~out_ready;
  assign in_ready = ~stall;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [N-1:0]   a_i, b_i, s_i, blk, mask;
    logic           c_i, v_i;
    logic [BLOCK:0] r0, r1, r;

    // Stage 0 folds subtraction into the operand: b inverted, carry-in inverted.
    if (g == 0) begin : g_first
      assign a_i = a;
      assign b_i = b ^ {N{sub}};
      assign s_i = '0;
      assign c_i = ci ^ sub;
      assign v_i = in_valid;
    end else begin : g_next
      assign a_i = a_q[g-1];
      assign b_i = b_q[g-1];
      assign s_i = s_q[g-1];
      assign c_i = c_q[g-1];
      assign v_i = v_q[g-1];
    end

    assign r0   = {1'b0, a_i[g*BLOCK +: BLOCK]} + {1'b0, b_i[g*BLOCK +: BLOCK]};
    assign r1   = r0 + {{BLOCK{1'b0}}, 1'b1};
    assign r    = c_i ? r1 : r0;
    assign blk  = N'(r[BLOCK-1:0]) << (g * BLOCK);
    assign mask = N'({BLOCK{1'b1}}) << (g * BLOCK);

    assign a_n[g] = a_i;
    assign b_n[g] = b_i;
    assign s_n[g] = (s_i & ~mask) | blk;
    assign c_n[g] = r[BLOCK];
    assign v_n[g] = v_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_n[k];
        b_q[k] <= b_n[k];
        s_q[k] <= s_n[k];
        c_q[k] <= c_n[k];
        v_q[k] <= v_n[k];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign co        = c_q[STAGES-1];

  // Last-stage operands matter only for the MSB carry; the rest is a sink.
  logic unused_tail;
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1]};

`ifdef CSA_PIPE_OVF_EN
  // Carry into the MSB is recovered as sum^a^b at bit N-1.
  assign ovf = s_q[STAGES-1][N-1] ^ a_q[STAGES-1][N-1] ^ b_q[STAGES-1][N-1] ^ c_q[STAGES-1];
`endif

endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb/tb_csa_pipe_adder.sv - self-checking bench for csa_pipe_adder (N=16/BLOCK=4 and N=4/BLOCK=2)
module tb_csa_pipe_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co;
  logic [15:0] a, b, sum;
  logic        s_in_valid, s_in_ready, s_ci, s_sub, s_out_valid, s_out_ready, s_co;
  logic [3:0]  s_a, s_b, s_sum;
`ifdef CSA_PIPE_OVF_EN
  logic        ovf, s_ovf;
`endif

  csa_pipe_adder #(.N(16), .BLOCK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .co(co)
`ifdef CSA_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  csa_pipe_adder #(.N(4), .BLOCK(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
    .ci(s_ci), .sub(s_sub), .out_valid(s_out_valid), .out_ready(s_out_ready), .sum(s_sum), .co(s_co)
`ifdef CSA_PIPE_OVF_EN
    , .ovf(s_ovf)
`endif
  );

  typedef struct {
    logic        v;
    logic [16:0] r;
    logic        o;
  } slot_t;

  // {co,sum} of a w-bit add/subtract, straight from the arithmetic definition.
  function automatic logic [16:0] ref_sum(int w, logic [15:0] x, logic [15:0] y, logic c, logic s);
    longint m, yy, r;
    m  = (longint'(1) << w) - 1;
    yy = s ? ((~longint'(y)) & m) : longint'(y);
    r  = longint'(x) + yy + longint'(s ? !c : c);
    r  = r & ((longint'(1) << (w + 1)) - 1);
    return r[16:0];
  endfunction

  // Signed overflow: true signed result falls outside the w-bit range.
  function automatic logic ref_ovf(int w, logic [15:0] x, logic [15:0] y, logic c, logic s);
    longint h, sx, sy, r;
    h  = longint'(1) << (w - 1);
    sx = (longint'(x) >= h) ? longint'(x) - 2 * h : longint'(x);
    sy = (longint'(y) >= h) ? longint'(y) - 2 * h : longint'(y);
    r  = s ? (sx - sy - longint'(c)) : (sx + sy + longint'(c));
    return (r >= h) || (r < -h);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({out_valid, co, sum} !== 18'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", {out_valid, co, sum});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if ({s_out_valid, s_co, s_sum} !== 6'd0 || s_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_small: got %h/%b expected 0/1", {s_out_valid, s_co, s_sum}, s_in_ready);
    end
`ifdef CSA_PIPE_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_ovf: got %b expected 0", ovf);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_exhaustive_small();
    logic [9:0]  i;
    logic [16:0] e;
    for (int c = 0; c < 1026; c++) begin
      if (c < 1024) begin
        s_in_valid = 1'b1;
        s_a = c[3:0]; s_b = c[7:4]; s_ci = c[8]; s_sub = c[9];
      end else begin
        s_in_valid = 1'b0;
      end
      #1;
      checks++;
      if (s_in_ready !== 1'b1) begin
        fails++;
        $display("FAIL exh_in_ready c=%0d: got %b expected 1", c, s_in_ready);
      end
      checks++;
      if (s_out_valid !== (c >= 2)) begin
        fails++;
        $display("FAIL exh_out_valid c=%0d: got %b expected %b", c, s_out_valid, c >= 2);
      end
      if (c >= 2) begin
        i = 10'(c - 2);
        e = ref_sum(4, 16'(i[3:0]), 16'(i[7:4]), i[8], i[9]);
        checks++;
        if ({s_co, s_sum} !== e[4:0]) begin
          fails++;
          $display("FAIL exh_sum op=%0d: got %h expected %h", i, {s_co, s_sum}, e[4:0]);
        end
`ifdef CSA_PIPE_OVF_EN
        checks++;
        if (s_ovf !== ref_ovf(4, 16'(i[3:0]), 16'(i[7:4]), i[8], i[9])) begin
          fails++;
          $display("FAIL exh_ovf op=%0d: got %b", i, s_ovf);
        end
`endif
      end
      tick();
    end
  endtask

  task automatic test_directed();
    logic [15:0] da [3];
    logic [15:0] db [3];
    logic        dc [3];
    logic        ds [3];
    logic [16:0] de [3];
    logic        dov [3];
    da = '{16'hFFFF, 16'h0000, 16'h8000};
    db = '{16'h0000, 16'h0001, 16'h0001};
    dc = '{1'b1, 1'b0, 1'b0};
    ds = '{1'b0, 1'b1, 1'b1};
    de = '{17'h10000, 17'h0FFFF, 17'h17FFF};
    dov = '{1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 6; c++) begin
        in_valid = (c == 0);
        a = da[t]; b = db[t]; ci = dc[t]; sub = ds[t];
        #1;
        checks++;
        if (out_valid !== (c == 4)) begin
          fails++;
          $display("FAIL dir%0d_latency c=%0d: got %b expected %b", t, c, out_valid, c == 4);
        end
        if (c == 4) begin
          checks++;
          if ({co, sum} !== de[t]) begin
            fails++;
            $display("FAIL dir%0d_sum: got %h expected %h", t, {co, sum}, de[t]);
          end
`ifdef CSA_PIPE_OVF_EN
          checks++;
          if (ovf !== dov[t]) begin
            fails++;
            $display("FAIL dir%0d_ovf: got %b expected %b", t, ovf, dov[t]);
          end
`endif
        end
        tick();
      end
    end
  endtask

  task automatic test_bubbles();
    logic [16:0] be [4];
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 4) && !c[0];
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      if (c < 4) be[c] = ref_sum(16, a, b, ci, sub);
      #1;
      checks++;
      if (out_valid !== (c >= 4 && c < 8 && !c[0])) begin
        fails++;
        $display("FAIL bubble_valid c=%0d: got %b", c, out_valid);
      end
      if (c >= 4 && c < 8 && !c[0]) begin
        checks++;
        if ({co, sum} !== be[c-4]) begin
          fails++;
          $display("FAIL bubble_sum c=%0d: got %h expected %h", c, {co, sum}, be[c-4]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    slot_t       q[$];
    slot_t       e;
    logic [15:0] oa [8];
    logic [15:0] ob [8];
    logic        oc [8];
    logic        os [8];
    logic [17:0] prev;
    logic        held;
    int          n_sent, n_got;
    for (int k = 0; k < 8; k++) begin
      oa[k] = 16'($urandom); ob[k] = 16'($urandom); oc[k] = 1'($urandom); os[k] = 1'($urandom);
    end
    n_sent = 0; n_got = 0; held = 1'b0; prev = '0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 5 && c <= 9);
      in_valid  = (n_sent < 8);
      if (n_sent < 8) begin
        a = oa[n_sent]; b = ob[n_sent]; ci = oc[n_sent]; sub = os[n_sent];
      end
      #1;
      checks++;
      if (in_ready !== !(c >= 5 && c <= 9)) begin
        fails++;
        $display("FAIL bp_in_ready c=%0d: got %b", c, in_ready);
      end
      if (held) begin
        checks++;
        if ({out_valid, co, sum} !== prev) begin
          fails++;
          $display("FAIL bp_hold c=%0d: got %h expected %h", c, {out_valid, co, sum}, prev);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL bp_extra c=%0d: got %h expected none", c, {co, sum});
        end else begin
          e = q.pop_front();
          n_got++;
          if ({co, sum} !== e.r) begin
            fails++;
            $display("FAIL bp_sum c=%0d: got %h expected %h", c, {co, sum}, e.r);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.v = 1'b1;
        e.r = ref_sum(16, a, b, ci, sub);
        e.o = ref_ovf(16, a, b, ci, sub);
        q.push_back(e);
        n_sent++;
      end
      prev = {out_valid, co, sum};
      held = out_valid && !out_ready;
      tick();
    end
    checks++;
    if (n_got != 8 || q.size() != 0) begin
      fails++;
      $display("FAIL bp_count: got %0d results expected 8 (pending %0d)", n_got, q.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic [16:0] ey;
    out_ready = 1'b1;
    ey = '0;
    for (int c = 0; c < 13; c++) begin
      if (c == 5) rst = 1'b0;
      in_valid = (c <= 2) || c == 4 || c == 5;
      ci = 1'b0; sub = 1'b0;
      if (c <= 2) begin
        a = 16'(16'h1111 * (c + 1)); b = 16'h0101;
      end else if (c == 4) begin
        a = 16'hAAAA; b = 16'h5555;
      end else if (c == 5) begin
        a = 16'h1234; b = 16'h4321; ci = 1'b1; sub = 1'b1;
        ey = ref_sum(16, a, b, ci, sub);
      end
      #1;
      if (c == 4) begin
        checks++;
        if ({out_valid, co, sum} !== {1'b1, 17'h01212}) begin
          fails++;
          $display("FAIL mid_before: got %h expected %h", {out_valid, co, sum}, {1'b1, 17'h01212});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, co, sum} !== 18'd0 || in_ready !== 1'b1) begin
          fails++;
          $display("FAIL mid_async_clear: got %h/%b expected 0/1", {out_valid, co, sum}, in_ready);
        end
      end
      if (c >= 5) begin
        checks++;
        if (out_valid !== (c == 9)) begin
          fails++;
          $display("FAIL mid_valid c=%0d: got %b expected %b", c, out_valid, c == 9);
        end
        if (c == 9) begin
          checks++;
          if ({co, sum} !== ey) begin
            fails++;
            $display("FAIL mid_sum: got %h expected %h", {co, sum}, ey);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    slot_t pipe [4];
    logic  st;
    for (int k = 0; k < 4; k++) begin
      pipe[k].v = 1'b0; pipe[k].r = '0; pipe[k].o = 1'b0;
    end
    for (int c = 0; c < 430; c++) begin
      in_valid  = (c < 400) && ($urandom_range(0, 9) < 7);
      out_ready = (c >= 400) || ($urandom_range(0, 9) < 7);
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      if (c % 50 == 7) begin
        a = 16'hFFFF; b = 16'hFFFF;
      end
      #1;
      st = pipe[3].v && !out_ready;
      checks++;
      if (in_ready !== !st) begin
        fails++;
        $display("FAIL rnd_in_ready c=%0d: got %b expected %b", c, in_ready, !st);
      end
      checks++;
      if (out_valid !== pipe[3].v) begin
        fails++;
        $display("FAIL rnd_valid c=%0d: got %b expected %b", c, out_valid, pipe[3].v);
      end
      if (pipe[3].v) begin
        checks++;
        if ({co, sum} !== pipe[3].r) begin
          fails++;
          $display("FAIL rnd_sum c=%0d: got %h expected %h", c, {co, sum}, pipe[3].r);
        end
`ifdef CSA_PIPE_OVF_EN
        checks++;
        if (ovf !== pipe[3].o) begin
          fails++;
          $display("FAIL rnd_ovf c=%0d: got %b expected %b", c, ovf, pipe[3].o);
        end
`endif
      end
      if (!st) begin
        for (int k = 3; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0].v = in_valid;
        pipe[0].r = ref_sum(16, a, b, ci, sub);
        pipe[0].o = ref_ovf(16, a, b, ci, sub);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_ci = 1'b0; s_sub = 1'b0; s_out_ready = 1'b1;
    test_reset();
    test_exhaustive_small();
    test_directed();
    test_bubbles();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
